// File: rtl/zxuno_flash_spi.sv
// SPI master for the boot/config flash behind the ZX-Uno SPI data and CS registers.
// Register strobes are edge-detected so each CPU I/O cycle triggers at most one action.
module zxuno_flash_spi #(
    parameter logic [7:0] REGSPI  = 8'h02,
    parameter logic [7:0] REGCS   = 8'h03,
    parameter int         HALFPER = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] zxuno_addr,
    input  logic       zxuno_regrd,
    input  logic       zxuno_regwr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       oe_n,
    output logic       flash_cs_n,
    output logic       flash_clk,
    output logic       flash_di,
    input  logic       flash_do,
    output logic       busy
);

    localparam int CW = (HALFPER > 1) ? $clog2(HALFPER) : 1;
    localparam logic [CW-1:0] HMAX = CW'(HALFPER - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    state_t        state;
    logic          regwr_d;
    logic          regrd_d;
    logic [7:0]    tx;
    logic [7:0]    rx_shift;
    logic [7:0]    rx_data;
    logic [2:0]    bit_cnt;
    logic [CW-1:0] hcnt;
    logic          overrun;
    logic          cs_pend;
    logic          cs_pend_val;

    logic          wr_ev;
    logic          rd_end;
    logic          start;
    logic          cs_wr;
    logic [7:0]    start_data;

    assign wr_ev      = zxuno_regwr & ~regwr_d;
    assign rd_end     = ~zxuno_regrd & regrd_d;
    assign start      = (wr_ev | rd_end) && (zxuno_addr == REGSPI);
    assign cs_wr      = wr_ev && (zxuno_addr == REGCS);
    // A read-end start is a read-ahead, so it clocks out all ones.
    assign start_data = wr_ev ? din : 8'hFF;

    always_comb begin
        dout = 8'hFF;
        oe_n = 1'b1;
        if (zxuno_regrd && zxuno_addr == REGSPI) begin
            dout = rx_data;
            oe_n = 1'b0;
        end else if (zxuno_regrd && zxuno_addr == REGCS) begin
            dout = {busy, overrun, 5'b00000, flash_cs_n};
            oe_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            regwr_d     <= 1'b0;
            regrd_d     <= 1'b0;
            tx          <= 8'hFF;
            rx_shift    <= 8'hFF;
            rx_data     <= 8'hFF;
            bit_cnt     <= 3'd0;
            hcnt        <= '0;
            overrun     <= 1'b0;
            cs_pend     <= 1'b0;
            cs_pend_val <= 1'b1;
            flash_cs_n  <= 1'b1;
            flash_clk   <= 1'b0;
            flash_di    <= 1'b1;
            busy        <= 1'b0;
        end else begin
            regwr_d <= zxuno_regwr;
            regrd_d <= zxuno_regrd;

            // CS changes mid-byte are deferred so the flash never sees CS move during a transfer.
            if (cs_wr) begin
                overrun <= 1'b0;
                if (state == IDLE) begin
                    flash_cs_n <= din[0];
                end else begin
                    cs_pend     <= 1'b1;
                    cs_pend_val <= din[0];
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOW;
                        tx        <= start_data;
                        flash_di  <= start_data[7];
                        flash_clk <= 1'b0;
                        busy      <= 1'b1;
                        bit_cnt   <= 3'd0;
                        hcnt      <= '0;
                    end
                end
                LOW: begin
                    if (hcnt == HMAX) begin
                        hcnt      <= '0;
                        flash_clk <= 1'b1;
                        state     <= HIGH;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (hcnt == HMAX) begin
                        hcnt      <= '0;
                        flash_clk <= 1'b0;
                        rx_shift  <= {rx_shift[6:0], flash_do};
                        if (bit_cnt == 3'd7) begin
                            rx_data  <= {rx_shift[6:0], flash_do};
                            flash_di <= 1'b1;
                            busy     <= 1'b0;
                            state    <= IDLE;
                            cs_pend  <= 1'b0;
                            if (cs_wr) begin
                                flash_cs_n <= din[0];
                            end else if (cs_pend) begin
                                flash_cs_n <= cs_pend_val;
                            end
                        end else begin
                            bit_cnt  <= bit_cnt + 3'd1;
                            tx       <= {tx[6:0], 1'b0};
                            flash_di <= tx[6];
                            state    <= LOW;
                        end
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (start && state != IDLE) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
